mc_datapath: RTL and testbench

Multi-cycle, parametrised successor to the single-cycle processor datapath. It fetches and decodes instructions over handshaked instruction and data memory ports, and runs each instruction through a fetch/decode/execute/memory/write-back state machine. It implements the full opcode set, including LD, ST, BR, JMP, JSR and JSRR, and maintains condition codes. It sits between the processor top level and the instruction/data memory models.

---
 rtl/datapath_pkg.sv | 39 +++
 rtl/mc_datapath_regfile.sv | 32 +++
 rtl/mc_datapath.sv | 200 ++++++++++++++++++++
 tb/tb_mc_datapath.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared opcodes, FSM states, condition codes and instruction field
// positions for the multi-cycle datapath.
package datapath_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB
  } state_t;

  localparam logic [4:0] OP_ADD  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_MOV  = 5'd3;
  localparam logic [4:0] OP_LD   = 5'd4;
  localparam logic [4:0] OP_ST   = 5'd5;
  localparam logic [4:0] OP_BR   = 5'd6;
  localparam logic [4:0] OP_JMP  = 5'd7;
  localparam logic [4:0] OP_JSR  = 5'd8;
  localparam logic [4:0] OP_JSRR = 5'd9;

  localparam logic [2:0] CC_N = 3'b100;
  localparam logic [2:0] CC_Z = 3'b010;
  localparam logic [2:0] CC_P = 3'b001;

  localparam int OP_LO  = 27;
  localparam int IMM_MB = 26;
  localparam int NZP_LO = 24;
  localparam int DST_LO = 20;
  localparam int S1_LO  = 16;
  localparam int S2_LO  = 8;
  localparam int IMM_LO = 0;

  function automatic logic [2:0] cc_of(logic neg, logic zero);
    return zero ? CC_Z : (neg ? CC_N : CC_P);
  endfunction

endpackage

// File: rtl/mc_datapath_regfile.sv
// Register file: two combinational read ports, one synchronous write
// port, asynchronous clear.
module dp_regfile #(
  parameter int W  = 16,
  parameter int N  = 8,
  parameter int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [W-1:0]  rd1,
  output logic [W-1:0]  rd2,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [W-1:0]  wd
);

  logic [W-1:0] mem [N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wa] <= wd;
    end
  end

  assign rd1 = mem[ra1];
  assign rd2 = mem[ra2];

endmodule

// File: rtl/mc_datapath.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB datapath with handshaked memories.
// Define DATAPATH_IMM_EN to let IR[26] select an immediate op2 for ALU ops.
module mc_datapath
  import datapath_pkg::*;
#(
  parameter int REG_WIDTH  = 16,
  parameter int REG_NUM    = 8,
  parameter int PC_WIDTH   = 16,
  parameter int INST_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lock,
  output logic                  imem_req,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic                  imem_ack,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [REG_WIDTH-1:0]  dmem_addr,
  output logic [REG_WIDTH-1:0]  dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [REG_WIDTH-1:0]  dmem_rdata,
  output logic [PC_WIDTH-1:0]   pc_o,
  output logic                  retire_o,
  output logic                  illegal_o
);

  localparam int AW = $clog2(REG_NUM);
  localparam logic [AW-1:0] LINK = AW'(REG_NUM - 1);

  state_t state_q, state_d;
  logic [INST_WIDTH-1:0] ir_q;
  logic [PC_WIDTH-1:0]   pc_q;
  logic [2:0]            cc_q;
  logic [REG_WIDTH-1:0]  a_q, b_q, res_q;
  logic [REG_WIDTH-1:0]  addr_q, wdata_q;
  logic                  we_q, ill_q;

  logic [4:0]           op;
  logic [AW-1:0]        dst, s1, s2, ra2;
  logic [REG_WIDTH-1:0] imm, op2, alu, rd1, rd2;
  logic [PC_WIDTH-1:0]  pc4, boff, tgt;
  logic is_add, is_and, is_mov, is_ld, is_st;
  logic is_br, is_jmp, is_jsr, is_jsrr;
  logic is_alu, is_mem, is_ill, br_take;
  logic rf_we;
  logic [AW-1:0]        rf_wa;
  logic [REG_WIDTH-1:0] rf_wd;
  logic                 unused_ir;

  assign op   = ir_q[OP_LO +: 5];
  assign dst  = ir_q[DST_LO +: AW];
  assign s1   = ir_q[S1_LO +: AW];
  assign s2   = ir_q[S2_LO +: AW];
  assign imm  = REG_WIDTH'($signed(ir_q[IMM_LO +: 16]));
  assign boff = PC_WIDTH'($signed(ir_q[IMM_LO +: 16])) << 2;
  assign pc4  = pc_q + PC_WIDTH'(4);
  assign unused_ir = ^ir_q;

  assign is_add  = op == OP_ADD;
  assign is_and  = op == OP_AND;
  assign is_mov  = op == OP_MOV;
  assign is_ld   = op == OP_LD;
  assign is_st   = op == OP_ST;
  assign is_br   = op == OP_BR;
  assign is_jmp  = op == OP_JMP;
  assign is_jsr  = op == OP_JSR;
  assign is_jsrr = op == OP_JSRR;
  assign is_alu  = is_add | is_and | is_mov;
  assign is_mem  = is_ld | is_st;
  assign is_ill  = ~(is_alu | is_mem | is_br | is_jmp | is_jsr | is_jsrr);
  assign br_take = |(ir_q[NZP_LO +: 3] & cc_q);

  // ST reads its data register through the second port
  assign ra2 = is_st ? dst : s2;

`ifdef DATAPATH_IMM_EN
  assign op2 = ir_q[IMM_MB] ? imm : b_q;
`else
  assign op2 = b_q;
`endif

  always_comb begin
    alu = '0;
    unique case (1'b1)
      is_add:  alu = a_q + op2;
      is_and:  alu = a_q & op2;
      is_mov:  alu = op2;
      default: alu = '0;
    endcase
  end

  always_comb begin
    tgt = pc4;
    unique case (1'b1)
      is_br:          tgt = br_take ? pc4 + boff : pc4;
      is_jsr:         tgt = pc4 + boff;
      is_jmp|is_jsrr: tgt = PC_WIDTH'(a_q);
      default:        tgt = pc4;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:  if (imem_req && imem_ack) state_d = DECODE;
      DECODE: state_d = EXEC;
      EXEC: begin
        unique case (1'b1)
          is_mem:  state_d = MEM;
          is_alu:  state_d = WB;
          default: state_d = FETCH;
        endcase
      end
      MEM:     if (dmem_ack) state_d = we_q ? FETCH : WB;
      WB:      state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      ir_q    <= '0;
      pc_q    <= '0;
      cc_q    <= CC_Z;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        FETCH: if (imem_req && imem_ack) ir_q <= imem_rdata;
        DECODE: begin
          a_q <= rd1;
          b_q <= rd2;
        end
        EXEC: begin
          res_q <= alu;
          if (is_mem) begin
            addr_q  <= a_q + imm;
            wdata_q <= b_q;
            we_q    <= is_st;
          end
          if (!is_alu && !is_mem) pc_q <= tgt;
          if (is_ill) ill_q <= 1'b1;
        end
        MEM: if (dmem_ack) begin
          if (we_q) pc_q <= pc4;
          else      res_q <= dmem_rdata;
        end
        WB: begin
          pc_q <= pc4;
          cc_q <= cc_of(res_q[REG_WIDTH-1], res_q == '0);
        end
        default: ;
      endcase
    end
  end

  // link write for JSR/JSRR happens in EXEC, ALU/LD results in WB
  assign rf_we = (state_q == WB) ||
                 (state_q == EXEC && (is_jsr || is_jsrr));
  assign rf_wa = (state_q == WB) ? dst : LINK;
  assign rf_wd = (state_q == WB) ? res_q : REG_WIDTH'(pc4);

  dp_regfile #(
    .W (REG_WIDTH),
    .N (REG_NUM),
    .AW(AW)
  ) u_rf (
    .clk(clk),
    .rst(rst),
    .ra1(s1),
    .ra2(ra2),
    .rd1(rd1),
    .rd2(rd2),
    .we (rf_we),
    .wa (rf_wa),
    .wd (rf_wd)
  );

  assign imem_req   = (state_q == FETCH) && lock && !rst;
  assign imem_addr  = pc_q;
  assign dmem_req   = state_q == MEM;
  assign dmem_we    = (state_q == MEM) && we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign pc_o       = pc_q;
  assign illegal_o  = ill_q;
  assign retire_o   = (state_q == WB) ||
                      (state_q == EXEC && !is_alu && !is_mem) ||
                      (state_q == MEM && we_q && dmem_ack);

endmodule

// File: tb/tb_mc_datapath.sv
// Scoreboard bench for mc_datapath: directed program, memory responders
// and a monitor checking retire PCs, latencies and data accesses.
module tb_mc_datapath;
  import datapath_pkg::*;

  logic        clk = 0;
  logic        rst = 1;
  logic        lock = 0;
  logic        imem_req, imem_ack = 0;
  logic [15:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        dmem_req, dmem_we, dmem_ack = 0;
  logic [15:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
  logic [15:0] pc_o;
  logic        retire_o, illegal_o;

  always #5 clk = ~clk;

  mc_datapath dut (
    .clk(clk), .rst(rst), .lock(lock),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .pc_o(pc_o), .retire_o(retire_o), .illegal_o(illegal_o)
  );

  typedef struct {logic we; logic [15:0] addr; logic [15:0] data;} dexp_t;
  typedef struct {logic [15:0] pc; int lat;} rexp_t;

  logic [31:0] imem [64];
  logic [15:0] dmem [32];
  dexp_t dq[$];
  rexp_t rq[$];
  dexp_t de;
  rexp_t re;
  int n_chk = 0, n_fail = 0, n_ret = 0;
  int icnt = 0, dcnt = 0, ilat = 0, cyc = 0;
  bit force_ack = 0, pend = 0;
  logic [15:0] pend_pc;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ri(logic [4:0] op, logic [2:0] m,
      logic [3:0] d, logic [3:0] s1, logic [15:0] imm);
    return {op, m, d, s1, imm};
  endfunction

  function automatic logic [31:0] rr(logic [4:0] op, logic [3:0] d,
      logic [3:0] s1, logic [3:0] s2);
    return ri(op, 3'b000, d, s1, {4'h0, s2, 8'h00});
  endfunction

  task automatic exp_ret(logic [15:0] pc, int lat);
    rq.push_back('{pc, lat});
  endtask

  task automatic exp_mem(logic we, logic [15:0] a, logic [15:0] d);
    dq.push_back('{we, a, d});
  endtask

  // instruction memory responder, ilat wait cycles per fetch
  always @(negedge clk) begin
    if (force_ack) begin
      imem_ack = 1;
    end else if (imem_req) begin
      if (icnt >= ilat) begin
        imem_ack = 1;
        imem_rdata = imem[imem_addr[7:2]];
        icnt = 0;
      end else begin
        imem_ack = 0;
        icnt++;
      end
    end else begin
      imem_ack = 0;
      icnt = 0;
    end
  end

  // data memory responder, address 5 answers after three waits
  always @(negedge clk) begin
    if (dmem_req) begin
      if (dcnt >= ((dmem_addr == 16'd5) ? 3 : 0)) begin
        dmem_ack = 1;
        if (dmem_we) dmem[dmem_addr[4:0]] = dmem_wdata;
        else dmem_rdata = dmem[dmem_addr[4:0]];
        dcnt = 0;
      end else begin
        dmem_ack = 0;
        dcnt++;
      end
    end else begin
      dmem_ack = 0;
      dcnt = 0;
    end
  end

  always @(negedge clk) begin
    #1;
    if (pend) begin
      pend = 0;
      chk("pc_after_retire", 32'(pc_o), 32'(pend_pc));
    end
    if (rst || !lock) cyc = 0;
    else cyc++;
    if (retire_o) begin
      n_ret++;
      if (rq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL retire: unexpected at pc %h want none", pc_o);
      end else begin
        re = rq.pop_front();
        if (re.lat != 0) chk("latency", 32'(cyc), 32'(re.lat));
        pend_pc = re.pc;
        pend = 1;
      end
      cyc = 0;
    end
    if (dmem_req && dmem_ack) begin
      if (dq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL dmem: unexpected access addr %h want none", dmem_addr);
      end else begin
        de = dq.pop_front();
        chk("dmem_we", 32'(dmem_we), 32'(de.we));
        chk("dmem_addr", 32'(dmem_addr), 32'(de.addr));
        if (de.we) chk("dmem_wdata", 32'(dmem_wdata), 32'(de.data));
      end
    end
  end

  task automatic run_until(int n);
    int k;
    for (k = 0; k < 3000; k++) begin
      @(posedge clk);
      if (n_ret >= n) break;
    end
    if (k == 3000) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: retired %0d want %0d", n_ret, n);
    end
    #2 lock = 0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) imem[i] = '0;
    for (int i = 0; i < 32; i++) dmem[i] = '0;
    dmem[1] = 16'h0002; dmem[2] = 16'hFFFF; dmem[3] = 16'h1234;
    dmem[4] = 16'h0040; dmem[6] = 16'h0060;

    imem[0]  = rr(OP_ADD, 1, 0, 0);
    imem[1]  = ri(OP_LD, 0, 6, 0, 16'd1);
    imem[2]  = ri(OP_LD, 0, 5, 0, 16'd2);
    imem[3]  = rr(OP_ADD, 6, 6, 5);
    imem[4]  = ri(OP_BR, 3'b001, 0, 0, 16'hFFFE);
    imem[5]  = ri(OP_ST, 0, 6, 0, 16'd9);
    imem[6]  = ri(OP_LD, 0, 3, 0, 16'd3);
    imem[7]  = ri(OP_ST, 0, 3, 0, 16'd5);
    imem[8]  = ri(OP_LD, 0, 4, 0, 16'd5);
    imem[9]  = ri(OP_ST, 0, 4, 0, 16'd10);
    imem[10] = ri(OP_LD, 0, 7, 0, 16'd4);
    imem[11] = ri(OP_ADD, 3'b100, 2, 0, 16'hFFFF);
    imem[12] = ri(OP_ST, 0, 2, 0, 16'd11);
    imem[13] = ri(OP_JSRR, 0, 0, 7, 16'd0);
    imem[16] = ri(OP_ST, 0, 7, 0, 16'd12);
    imem[17] = ri(OP_JSR, 0, 0, 0, 16'd2);
    imem[20] = ri(OP_ST, 0, 7, 0, 16'd13);
    imem[21] = ri(OP_LD, 0, 6, 0, 16'd6);
    imem[22] = ri(OP_JMP, 0, 0, 6, 16'd0);
    imem[24] = rr(OP_AND, 1, 3, 6);
    imem[25] = ri(OP_ST, 0, 1, 0, 16'd14);
    imem[26] = rr(OP_MOV, 1, 0, 5);
    imem[27] = ri(OP_ST, 0, 1, 0, 16'd15);
    imem[28] = rr(OP_ADD, 1, 5, 5);
    imem[29] = ri(OP_ST, 0, 1, 0, 16'd16);
    imem[30] = {5'h1F, 27'h0};

    exp_ret(16'h04, 4); exp_ret(16'h08, 5); exp_ret(16'h0C, 5);
    exp_ret(16'h10, 4); exp_ret(16'h0C, 3); exp_ret(16'h10, 4);
    exp_ret(16'h14, 3); exp_ret(16'h18, 4); exp_ret(16'h1C, 5);
    exp_ret(16'h20, 7); exp_ret(16'h24, 8); exp_ret(16'h28, 4);
    exp_ret(16'h2C, 5); exp_ret(16'h30, 4); exp_ret(16'h34, 4);
    exp_ret(16'h40, 3); exp_ret(16'h44, 4); exp_ret(16'h50, 3);
    exp_ret(16'h54, 4); exp_ret(16'h58, 5); exp_ret(16'h60, 3);
    exp_ret(16'h64, 4); exp_ret(16'h68, 4); exp_ret(16'h6C, 4);
    exp_ret(16'h70, 4); exp_ret(16'h74, 4); exp_ret(16'h78, 4);
    exp_ret(16'h7C, 3);

    exp_mem(0, 1, 0); exp_mem(0, 2, 0); exp_mem(1, 9, 16'h0000);
    exp_mem(0, 3, 0); exp_mem(1, 5, 16'h1234); exp_mem(0, 5, 0);
    exp_mem(1, 10, 16'h1234); exp_mem(0, 4, 0);
`ifdef DATAPATH_IMM_EN
    exp_mem(1, 11, 16'hFFFF);
`else
    exp_mem(1, 11, 16'h0040);
`endif
    exp_mem(1, 12, 16'h0038); exp_mem(1, 13, 16'h0048);
    exp_mem(0, 6, 0); exp_mem(1, 14, 16'h0020);
    exp_mem(1, 15, 16'hFFFF); exp_mem(1, 16, 16'hFFFE);

    lock = 1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_imem_req", 32'(imem_req), 0);
    chk("rst_pc", 32'(pc_o), 0);
    chk("rst_imem_addr", 32'(imem_addr), 0);
    chk("rst_dmem_req", 32'(dmem_req), 0);
    chk("rst_retire", 32'(retire_o), 0);
    chk("rst_illegal", 32'(illegal_o), 0);
    chk("rst_dmem_addr", 32'({dmem_we, dmem_addr, dmem_wdata}), 0);
    rst = 0;

    run_until(28);
    @(negedge clk); #2;
    chk("illegal_sticky", 32'(illegal_o), 1);
    chk("end_pc", 32'(pc_o), 32'h7C);
    chk("idle_req", 32'(imem_req), 0);
    chk("rq_drained", 32'(rq.size()), 0);
    chk("dq_drained", 32'(dq.size()), 0);

    ilat = 1000;
    @(posedge clk); #2 lock = 1;
    repeat (3) @(negedge clk);
    #2;
    chk("wait_req", 32'(imem_req), 1);
    chk("wait_addr", 32'(imem_addr), 32'h7C);
    rst = 1;
    #1;
    chk("midrst_req", 32'(imem_req), 0);
    chk("midrst_pc", 32'(pc_o), 0);
    chk("midrst_illegal", 32'(illegal_o), 0);
    chk("midrst_retire", 32'(retire_o), 0);
    @(posedge clk); #2 lock = 0;
    @(posedge clk); #2 rst = 0; force_ack = 1;
    @(posedge clk); #2 force_ack = 0;
    repeat (4) @(posedge clk);
    #2;
    chk("late_ack_pc", 32'(pc_o), 0);
    chk("late_ack_req", 32'(imem_req), 0);
    chk("late_ack_illegal", 32'(illegal_o), 0);

    ilat = 0;
    exp_ret(16'h04, 4);
    lock = 1;
    run_until(29);
    repeat (3) @(posedge clk);
    chk("final_rq", 32'(rq.size()), 0);
    chk("final_pc", 32'(pc_o), 32'h04);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
